// File: rtl/acc_dump_pkg.sv
// Shared types and constants for the accumulator dump sequencer.
// Used by acc_dump; the checksum byte is built only with ACC_DUMP_CHECKSUM_EN.
package acc_dump_pkg;

  localparam int         ACC_BYTES       = 16;
  localparam logic [7:0] ACC_DUMP_HEADER = 8'hA5;

  typedef enum logic [3:0] {
    ACC_DUMP_IDLE   = 4'd0,
    ACC_DUMP_HDR    = 4'd1,
    ACC_DUMP_SETSEL = 4'd2,
    ACC_DUMP_CAPT   = 4'd3,
    ACC_DUMP_GO     = 4'd4,
    ACC_DUMP_GUARD  = 4'd5,
    ACC_DUMP_DRAIN  = 4'd6,
    ACC_DUMP_CSUM   = 4'd7,
    ACC_DUMP_FIN    = 4'd8
  } acc_dump_state_e;

  // Kind of the byte currently in flight; DRAIN uses it to pick what follows.
  typedef enum logic [1:0] {
    ACC_ITEM_HDR  = 2'd0,
    ACC_ITEM_DATA = 2'd1,
    ACC_ITEM_CSUM = 2'd2
  } acc_dump_item_e;

  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

endpackage

// File: rtl/acc_dump.sv
// Streams the 128-bit accumulator to the UART, MSB byte first, framed by a header byte.
// Define ACC_DUMP_CHECKSUM_EN to append an XOR checksum byte to each frame.
module acc_dump
  import acc_dump_pkg::*;
#(
  parameter int         NBYTES = ACC_BYTES,
  parameter int         SEL_W  = 4,
  parameter logic [7:0] HEADER = ACC_DUMP_HEADER
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             busy_tx,
  input  logic [7:0]       mux_data,
  output logic [SEL_W-1:0] sel,
  output logic             transmit,
  output logic [7:0]       data_tx,
  output logic             lock,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NBYTES - 1);

  acc_dump_state_e r_state;
  acc_dump_state_e w_state_next;
  acc_dump_item_e  r_kind;
  acc_dump_item_e  w_kind_next;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] w_idx_next;
  logic [SEL_W-1:0] r_sel;
  logic             r_transmit;
  logic [7:0]       r_data_tx;
  logic             r_lock;
  logic             r_done;
  logic             w_load_hdr;
  logic             w_load_data;
  logic             w_load_csum;

  // Next-state, byte index and item-kind decode
  always_comb begin
    w_state_next = r_state;
    w_kind_next  = r_kind;
    w_idx_next   = r_idx;
    w_load_hdr   = 1'b0;
    w_load_data  = 1'b0;
    w_load_csum  = 1'b0;
    case (r_state)
      ACC_DUMP_IDLE: begin
        if (start) begin
          w_state_next = ACC_DUMP_HDR;
          w_idx_next   = '0;
        end else begin
          w_state_next = ACC_DUMP_IDLE;
        end
      end
      ACC_DUMP_HDR: begin
        if (!busy_tx) begin
          w_state_next = ACC_DUMP_GO;
          w_kind_next  = ACC_ITEM_HDR;
          w_load_hdr   = 1'b1;
        end else begin
          w_state_next = ACC_DUMP_HDR;
        end
      end
      ACC_DUMP_SETSEL: w_state_next = ACC_DUMP_CAPT;
      ACC_DUMP_CAPT: begin
        if (!busy_tx) begin
          w_state_next = ACC_DUMP_GO;
          w_kind_next  = ACC_ITEM_DATA;
          w_load_data  = 1'b1;
        end else begin
          w_state_next = ACC_DUMP_CAPT;
        end
      end
      ACC_DUMP_GO:    w_state_next = ACC_DUMP_GUARD;
      // The UART raises busy a cycle after the strobe, so GUARD must not look at it.
      ACC_DUMP_GUARD: w_state_next = ACC_DUMP_DRAIN;
      ACC_DUMP_DRAIN: begin
        if (!busy_tx) begin
          case (r_kind)
            ACC_ITEM_HDR: begin
              w_state_next = ACC_DUMP_SETSEL;
              w_idx_next   = '0;
            end
            ACC_ITEM_DATA: begin
              if (r_idx == LAST_IDX) begin
`ifdef ACC_DUMP_CHECKSUM_EN
                w_state_next = ACC_DUMP_CSUM;
`else
                w_state_next = ACC_DUMP_FIN;
`endif
              end else begin
                w_state_next = ACC_DUMP_SETSEL;
                w_idx_next   = r_idx + SEL_W'(1);
              end
            end
            ACC_ITEM_CSUM: w_state_next = ACC_DUMP_FIN;
            default:       w_state_next = ACC_DUMP_IDLE;
          endcase
        end else begin
          w_state_next = ACC_DUMP_DRAIN;
        end
      end
`ifdef ACC_DUMP_CHECKSUM_EN
      ACC_DUMP_CSUM: begin
        w_state_next = ACC_DUMP_GO;
        w_kind_next  = ACC_ITEM_CSUM;
        w_load_csum  = 1'b1;
      end
`endif
      ACC_DUMP_FIN: w_state_next = ACC_DUMP_IDLE;
      default:      w_state_next = ACC_DUMP_IDLE;
    endcase
  end

  // State, byte index and item-kind registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= ACC_DUMP_IDLE;
      r_kind  <= ACC_ITEM_HDR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_kind  <= w_kind_next;
      r_idx   <= w_idx_next;
    end
  end

`ifdef ACC_DUMP_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running XOR of header and data bytes
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_csum <= 8'h00;
    end else if (w_load_hdr) begin
      r_csum <= HEADER;
    end else if (w_load_data) begin
      r_csum <= csum_next(r_csum, mux_data);
    end else begin
      r_csum <= r_csum;
    end
  end
`endif

  // Registered outputs, derived from the upcoming state so they align with it
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sel      <= '0;
      r_transmit <= 1'b0;
      r_data_tx  <= 8'h00;
      r_lock     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_transmit <= (w_state_next == ACC_DUMP_GO);
      r_done     <= (w_state_next == ACC_DUMP_FIN);

      if ((r_state == ACC_DUMP_IDLE) && start) begin
        r_lock <= 1'b1;
      end else if (w_state_next == ACC_DUMP_FIN) begin
        r_lock <= 1'b0;
      end else begin
        r_lock <= r_lock;
      end

      // MSB-first: byte index 0 selects the top accumulator byte.
      if (w_state_next == ACC_DUMP_SETSEL) begin
        r_sel <= LAST_IDX - w_idx_next;
      end else if (w_state_next == ACC_DUMP_FIN) begin
        r_sel <= '0;
      end else begin
        r_sel <= r_sel;
      end

      if (w_load_hdr) begin
        r_data_tx <= HEADER;
      end else if (w_load_data) begin
        r_data_tx <= mux_data;
`ifdef ACC_DUMP_CHECKSUM_EN
      end else if (w_load_csum) begin
        r_data_tx <= r_csum;
`endif
      end else begin
        r_data_tx <= r_data_tx;
      end
    end
  end

`ifndef ACC_DUMP_CHECKSUM_EN
  logic w_unused;
  assign w_unused = w_load_csum;
`endif

  assign sel      = r_sel;
  assign transmit = r_transmit;
  assign data_tx  = r_data_tx;
  assign lock     = r_lock;
  assign done     = r_done;

endmodule

// File: tb/tb_acc_dump.sv
// Scoreboard bench for acc_dump: a UART/mux model feeds the DUT, expected bytes are
// queued at stimulus time and a negedge monitor pops and compares on every strobe.
module tb_acc_dump;
  import acc_dump_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    bit         chk_s;
  } exp_t;

  logic         clk = 1'b0;
  logic         nRst;
  logic         start;
  logic         busy_tx;
  logic [7:0]   mux_data;
  logic [3:0]   sel;
  logic         transmit;
  logic [7:0]   data_tx;
  logic         lock;
  logic         done;

  logic [127:0] acc = 128'h0;
  int           busy_cnt = 0;
  bit           force_busy = 1'b0;
  int           cyc = 0;
  int           n_tx = 0;
  int           last_tx_cyc = 0;
  int           done_cnt = 0;
  int           n_vec = 0;
  int           n_err = 0;
  exp_t         q[$];

`ifdef ACC_DUMP_CHECKSUM_EN
  localparam int FRAME_LEN = 18;
`else
  localparam int FRAME_LEN = 17;
`endif

  acc_dump dut (
    .clk(clk), .nRst(nRst), .start(start), .busy_tx(busy_tx), .mux_data(mux_data),
    .sel(sel), .transmit(transmit), .data_tx(data_tx), .lock(lock), .done(done)
  );

  always #5 clk = ~clk;

  assign mux_data = acc[{sel, 3'b000} +: 8];
  assign busy_tx  = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (transmit) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: one pop-and-compare per transmit strobe
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (transmit) begin
      n_tx++;
      last_tx_cyc = cyc;
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_tx got=%0h expected=none", data_tx);
      end else begin
        e = q.pop_front();
        check("tx_byte", {24'h0, data_tx}, {24'h0, e.d});
        if (e.chk_s) check("sel", {28'h0, sel}, {28'h0, e.s});
        check("lock_during_tx", {31'h0, lock}, 32'h1);
      end
    end
  end

  task automatic push_frame(input logic [127:0] a, input logic [7:0] exp_csum);
    exp_t e;
    e.d = 8'hA5; e.s = 4'h0; e.chk_s = 1'b0;
    q.push_back(e);
    for (int i = 0; i < 16; i++) begin
      e.d = a[(15 - i) * 8 +: 8];
      e.s = 4'(15 - i);
      e.chk_s = 1'b1;
      q.push_back(e);
    end
`ifdef ACC_DUMP_CHECKSUM_EN
    e.d = exp_csum; e.s = 4'h0; e.chk_s = 1'b0;
    q.push_back(e);
`else
    if (exp_csum == 8'h00) e.chk_s = 1'b0;
`endif
  endtask

  task automatic run_frame(input logic [127:0] a, input logic [7:0] exp_csum,
                           input int restart_at, input bit busy_hold);
    int base_tx, base_done, exp_first, k;
    bit restarted;
    acc = a;
    push_frame(a, exp_csum);
    base_tx = n_tx;
    base_done = done_cnt;
    restarted = 1'b0;
    @(posedge clk); #1;
    if (busy_hold) force_busy = 1'b1;
    start = 1'b1;
    exp_first = cyc + 2;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy_hold) begin
      repeat (49) @(posedge clk);
      #1;
      check("no_tx_while_busy", n_tx - base_tx, 0);
      check("lock_while_stalled", {31'h0, lock}, 32'h1);
      force_busy = 1'b0;
      exp_first = cyc + 1;
    end
    k = 0;
    while (n_tx == base_tx && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_tx == base_tx) check("hdr_strobe_timeout", 0, 1);
    else check("hdr_strobe_cycle", last_tx_cyc, exp_first);
    k = 0;
    while (done_cnt == base_done && k < 3000) begin
      if (restart_at >= 0 && !restarted && (n_tx - base_tx) == restart_at + 2) begin
        start = 1'b1;
        restarted = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      k++;
    end
    if (done_cnt == base_done) check("done_timeout", 0, 1);
    repeat (40) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - base_done, 1);
    check("frame_len", n_tx - base_tx, FRAME_LEN);
    check("queue_drained", q.size(), 0);
    check("lock_after_done", {31'h0, lock}, 32'h0);
    check("sel_after_done", {28'h0, sel}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},      {28'h0, sel},      32'h0);
    check({tag, "_transmit"}, {31'h0, transmit}, 32'h0);
    check({tag, "_data_tx"},  {24'h0, data_tx},  32'h0);
    check({tag, "_lock"},     {31'h0, lock},     32'h0);
    check({tag, "_done"},     {31'h0, done},     32'h0);
  endtask

  initial begin
    int base_tx, base_done, k;
    nRst = 1'b0;
    start = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All-zero accumulator: checksum is just the header
    run_frame(128'h0, 8'hA5, -1, 1'b0);
    // Counting pattern: data XOR cancels to 00, checksum A5
    run_frame(128'h00112233445566778899AABBCCDDEEFF, 8'hA5, -1, 1'b0);
    // Only byte0 set: last data byte 01, checksum A4
    run_frame(128'h01, 8'hA4, -1, 1'b0);
    // Second start during byte 5 must be ignored
    run_frame(128'hDEADBEEF_00000000_00000000_CAFEF00D, 8'h4E, 5, 1'b0);
    // Start while UART busy for 50 cycles
    run_frame({8'h80, 120'h0}, 8'h25, -1, 1'b1);

    // Reset during byte 8 drain
    acc = 128'h00112233445566778899AABBCCDDEEFF;
    push_frame(acc, 8'hA5);
    base_tx = n_tx;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while ((n_tx - base_tx) < 10 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if ((n_tx - base_tx) < 10) check("byte8_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1 nRst = 1'b0;
    base_done = done_cnt;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt - base_done, 0);
    run_frame(128'h00112233445566778899AABBCCDDEEFF, 8'hA5, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/acc_dump.md
Name: acc_dump

Overview:
- Sequencer that streams the 128-bit accumulator result to the host over the UART transmitter, one byte at a time.
- Steps the byte-mux select, captures each selected byte, and pulses the UART transmit strobe. Honours the transmitter busy handshake.
- Frames each dump with a header byte and an optional XOR checksum.
- Sits between ctrl (start request), mux (sel/byte) and uart (transmit/data_tx/busy_tx). Raises a lock flag so the accumulator is not modified mid-dump.

Parameters:
- NBYTES, 16, number of accumulator bytes per dump (128/8).
- SEL_W, 4, width of the mux select; must satisfy 2**SEL_W >= NBYTES.
- HEADER, 8'hA5, frame start byte sent before data.

Ports:
- clk  in  1  clock (divided system clock domain)
- nRst  in  1  asynchronous active-low reset
- start  in  1  single-cycle dump request from ctrl
- busy_tx  in  1  UART transmitter busy
- mux_data  in  8  byte currently selected by mux
- sel  out  SEL_W  mux byte select
- transmit  out  1  one-cycle UART transmit strobe
- data_tx  out  8  byte presented to UART, registered
- lock  out  1  high while a dump is in progress; ctrl must not assert acc/clear
- done  out  1  one-cycle pulse when the last byte's transmission completes

Behaviour:
- Reset is nRst, asynchronous, active-low; clock is clk.
- Reset values: sel=0, transmit=0, data_tx=0, lock=0, done=0, state=IDLE, byte counter=0, checksum=0.
- Reset asserted mid-dump returns immediately to IDLE. A partially sent frame is abandoned and no done pulse is produced.
- States: IDLE, HDR, SETSEL, CAPT, GO, GUARD, DRAIN, CSUM, FIN.
- IDLE:
  - start=1 -> HDR; lock=1 from the next cycle.
  - start is ignored in every other state, with no queueing.
- HDR: waits for busy_tx=0, then loads data_tx=HEADER and checksum=HEADER -> GO.
- SETSEL: sel=NBYTES-1-idx, giving MSB-first order (sel=0 is bits [7:0]) -> CAPT. This is one settle cycle for the combinational mux.
- CAPT: waits for busy_tx=0, then data_tx<=mux_data and checksum^=mux_data -> GO.
- GO: transmit=1 for exactly one cycle -> GUARD.
- GUARD: one cycle that ignores busy_tx (the UART raises busy one cycle after the strobe) -> DRAIN.
- DRAIN: waits until busy_tx=0. Next state:
  - last item was the header -> SETSEL with idx=0;
  - data byte and idx<NBYTES-1 -> idx++, SETSEL;
  - data byte and idx=NBYTES-1 -> CSUM if the feature is enabled, else FIN;
  - checksum byte was sent -> FIN.
- CSUM: data_tx<=checksum -> GO.
- FIN: done=1 for one cycle, lock=0, sel=0 -> IDLE.
- Per-byte minimum cost: 4 cycles plus the UART busy time. Header transmit strobe occurs 2 cycles after start when busy_tx=0.
- start coincident with busy_tx=1: accepted. HDR stalls until busy drops.
- busy_tx stuck high: FSM waits indefinitely with lock held. There is no timeout.
- Byte counter wraps never: bounded by NBYTES-1.

Optional Feature:
- Macro: ACC_DUMP_CHECKSUM_EN.
- When defined: after the last data byte, one extra byte equal to the XOR of HEADER and all data bytes is sent. Frame length is NBYTES+2.
- When undefined: the CSUM state and checksum register are not built, DRAIN after the last data byte goes straight to FIN, and frame length is NBYTES+1.

Decomposition:
- Shared package: state encoding enum (ACC_DUMP_IDLE..FIN), HEADER default 8'hA5, ACC_BYTES=16.
- No sub-module needed. A tiny byte_tx_hs sub-module (GO/GUARD/DRAIN handshake) is natural if ctrl later reuses it.

Test Plan:
- acc=128'h0, UART model busy 10 cycles, checksum on -> frame A5, 00 x16, A5; done pulses once; lock high for the full frame.
- acc=128'h00112233445566778899AABBCCDDEEFF -> bytes A5,00,11,...,FF in MSB-first order; checksum = A5 ^ XOR(all data) = A5^00 = A5. Also check sel sequence 15..0.
- acc byte0=8'h01, all other bytes 0, checksum on -> last data byte 01, checksum A4. With the macro off: frame is 17 bytes, no checksum, done after byte 01.
- start pulsed again at byte 5 -> ignored; exactly one frame is sent and one done pulse is produced.
- busy_tx held high at start for 50 cycles -> no transmit strobe until busy falls; header strobe 1 cycle after busy falls.
- nRst asserted during byte 8 DRAIN -> all outputs reset values immediately; no done. A new start after reset sends a complete fresh frame.
